// File: rtl/minterm_pkg.sv
// Shared definitions for the minterm extractor: default variable count,
// truth-table width helper and the extraction FSM state encoding.
package minterm_pkg;

    localparam int N_VARS_DEF = 4;

    // Truth-table width for a given number of Boolean variables.
    function automatic int tt_width(input int n_vars);
        return 32'sd1 << n_vars;
    endfunction

    localparam int TT_WIDTH = tt_width(N_VARS_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/minterm_any_above.sv
// Reports whether any bit of the captured truth table lies strictly above
// the given index. Used to qualify the last emitted minterm.
module minterm_any_above
    import minterm_pkg::*;
#(
    parameter int N_VARS = N_VARS_DEF
) (
    input  logic [tt_width(N_VARS)-1:0] table_i,
    input  logic [N_VARS-1:0]           idx_i,
    output logic                        any_o
);

    logic [tt_width(N_VARS)-1:0] above_s;

    // Drop bits at and below idx_i, then OR-reduce what remains.
    always_comb begin
        above_s = (table_i >> idx_i) >> 1'b1;
        any_o   = |above_s;
    end

endmodule

// File: rtl/minterm_extractor.sv
// Minterm extractor: captures a truth table on start and emits the index of
// every set bit in ascending order over a valid/ready stream, one SCAN cycle
// per clear bit. Optional feature macro MINTERM_EXTRACTOR_MAXTERM_EN adds a
// sel_max input that inverts the captured table so maxterms are emitted.
module minterm_extractor
    import minterm_pkg::*;
#(
    parameter int N_VARS = N_VARS_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [tt_width(N_VARS)-1:0] tt_in,
`ifdef MINTERM_EXTRACTOR_MAXTERM_EN
    input  logic                        sel_max,
`endif
    output logic                        busy,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [N_VARS-1:0]           m_index,
    output logic                        m_last,
    output logic                        done,
    output logic [N_VARS:0]             count
);

    localparam int TT_W = tt_width(N_VARS);
    localparam logic [N_VARS-1:0] IDX_MAX = {N_VARS{1'b1}};
    localparam logic [N_VARS-1:0] IDX_ONE = {{(N_VARS-1){1'b0}}, 1'b1};
    localparam logic [N_VARS:0]   CNT_ONE = {{N_VARS{1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [N_VARS-1:0]   idx_q, idx_d;
    logic [TT_W-1:0]     table_q, table_d;
    logic [N_VARS:0]     count_q, count_d;
    logic                m_last_q, m_last_d;
    logic                busy_q, m_valid_q, done_q;
    logic [TT_W-1:0]     start_table_s;
    logic                any_above_s;

    // Select the table image to capture: raw, or inverted for maxterm mode.
    always_comb begin
`ifdef MINTERM_EXTRACTOR_MAXTERM_EN
        if (sel_max) begin
            start_table_s = ~tt_in;
        end else begin
            start_table_s = tt_in;
        end
`else
        start_table_s = tt_in;
`endif
    end

    minterm_any_above #(
        .N_VARS (N_VARS)
    ) u_any_above (
        .table_i (table_q),
        .idx_i   (idx_q),
        .any_o   (any_above_s)
    );

    // Next-state logic for scan position, captured table, count and m_last.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        table_d  = table_q;
        count_d  = count_q;
        m_last_d = m_last_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    table_d  = start_table_s;
                    count_d  = {(N_VARS+1){1'b0}};
                    idx_d    = {N_VARS{1'b0}};
                    m_last_d = 1'b0;
                    state_d  = SCAN;
                end else begin
                    state_d  = IDLE;
                end
            end
            SCAN: begin
                if (table_q[idx_q]) begin
                    // Last flag is resolved here so it is stable through EMIT.
                    m_last_d = ~any_above_s;
                    state_d  = EMIT;
                end else if (idx_q == IDX_MAX) begin
                    state_d  = DONE;
                end else begin
                    idx_d    = idx_q + IDX_ONE;
                end
            end
            EMIT: begin
                if (m_ready) begin
                    count_d  = count_q + CNT_ONE;
                    m_last_d = 1'b0;
                    if (idx_q == IDX_MAX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = SCAN;
                    end
                end else begin
                    state_d = EMIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; status outputs registered from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= {N_VARS{1'b0}};
            table_q   <= {TT_W{1'b0}};
            count_q   <= {(N_VARS+1){1'b0}};
            m_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            m_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            table_q   <= table_d;
            count_q   <= count_d;
            m_last_q  <= m_last_d;
            busy_q    <= (state_d != IDLE);
            m_valid_q <= (state_d == EMIT);
            done_q    <= (state_d == DONE);
        end
    end

    assign busy    = busy_q;
    assign m_valid = m_valid_q;
    assign m_index = idx_q;
    assign m_last  = m_last_q;
    assign done    = done_q;
    assign count   = count_q;

endmodule

// File: tb/tb_minterm_extractor.sv
// Scoreboard bench for minterm_extractor: directed tables push hand-computed
// (index, last) pairs; a negedge monitor pops and compares on each transfer.
module tb_minterm_extractor;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] tt_in;
    logic        sel_max_r;
    logic        busy;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  m_index;
    logic        m_last;
    logic        done;
    logic [4:0]  count;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    logic [4:0] exp_q[$];

    logic       prev_stall = 1'b0;
    logic       prev_xfer  = 1'b0;
    logic [3:0] held_idx   = 4'd0;

    minterm_extractor #(.N_VARS(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .tt_in   (tt_in),
`ifdef MINTERM_EXTRACTOR_MAXTERM_EN
        .sel_max (sel_max_r),
`endif
        .busy    (busy),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_index (m_index),
        .m_last  (m_last),
        .done    (done),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int idx, input bit last);
        exp_q.push_back({last, idx[3:0]});
    endtask

    // Monitor: compare each transfer against the scoreboard, check stall hold.
    always @(negedge clk) begin
        logic [4:0] e;
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_xfer  = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_hold", {31'd0, m_valid}, 32'd1);
                check("stall_index_hold", {28'd0, m_index}, {28'd0, held_idx});
            end
            if (prev_xfer) begin
                check("valid_drop_after_xfer", {31'd0, m_valid}, 32'd0);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_index: got %0d expected none", m_index);
                end else begin
                    e = exp_q.pop_front();
                    check("m_index", {28'd0, m_index}, {28'd0, e[3:0]});
                    check("m_last", {31'd0, m_last}, {31'd0, e[4]});
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_xfer  = m_valid && m_ready;
            held_idx   = m_index;
            if (done) done_cnt++;
        end
    end

    // Issue start now (caller positions just after an edge) and run to done.
    task automatic run(input logic [15:0] tt, input bit tog, input bit inj, input bit smax,
                       output int lat_first, output int lat_done);
        int cyc;
        done_cnt  = 0;
        lat_first = -1;
        lat_done  = -1;
        start     = 1'b1;
        tt_in     = tt;
        sel_max_r = smax;
        m_ready   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 0;
        while (cyc < 200 && lat_done < 0) begin
            if (m_valid && lat_first < 0) lat_first = cyc + 1;
            if (done) begin
                lat_done = cyc + 1;
            end else begin
                if (inj && cyc == 3) begin
                    start = 1'b1;
                    tt_in = 16'h0001;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
                cyc++;
                if (tog) m_ready = ~m_ready;
            end
        end
        check("done_seen", {31'd0, lat_done >= 0}, 32'd1);
        start   = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("done_pulse_count", done_cnt, 32'd1);
        check("busy_after_done", {31'd0, busy}, 32'd0);
        check("scoreboard_empty", exp_q.size(), 32'd0);
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (!m_valid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("valid_seen", {31'd0, m_valid}, 32'd1);
    endtask

    initial begin
        int lf;
        int ld;
        rst_n     = 1'b0;
        start     = 1'b0;
        tt_in     = 16'h0000;
        sel_max_r = 1'b0;
        m_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, m_valid}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_count", {27'd0, count}, 32'd0);
        check("rst_index", {28'd0, m_index}, 32'd0);
        #2 rst_n = 1'b1;

        // 16'hAA25 with m_ready held high
        @(posedge clk); #1;
        push(0, 0); push(2, 0); push(5, 0); push(9, 0);
        push(11, 0); push(13, 0); push(15, 1);
        run(16'hAA25, 1'b0, 1'b0, 1'b0, lf, ld);
        check("aa25_first_latency", lf, 32'd2);
        check("aa25_count", {27'd0, count}, 32'd7);

        // All-zero table
        @(posedge clk); #1;
        run(16'h0000, 1'b0, 1'b0, 1'b0, lf, ld);
        check("zero_no_valid", lf, 32'hFFFF_FFFF);
        check("zero_done_latency", ld, 32'd17);
        check("zero_count", {27'd0, count}, 32'd0);

        // All-ones table with m_ready toggling
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) push(i, i == 15);
        run(16'hFFFF, 1'b1, 1'b0, 1'b0, lf, ld);
        check("ffff_count", {27'd0, count}, 32'd16);

        // Single top bit, second start while busy ignored
        @(posedge clk); #1;
        push(15, 1);
        run(16'h8000, 1'b0, 1'b1, 1'b0, lf, ld);
        check("8000_first_latency", lf, 32'd17);
        check("8000_count", {27'd0, count}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("8000_stays_idle", {31'd0, busy}, 32'd0);

`ifdef MINTERM_EXTRACTOR_MAXTERM_EN
        // Maxterm extraction of 16'hAA25
        @(posedge clk); #1;
        push(1, 0); push(3, 0); push(4, 0); push(6, 0); push(7, 0);
        push(8, 0); push(10, 0); push(12, 0); push(14, 1);
        run(16'hAA25, 1'b0, 1'b0, 1'b1, lf, ld);
        check("maxterm_count", {27'd0, count}, 32'd9);
        sel_max_r = 1'b0;
`endif

        // Reset mid-EMIT while index 5 is held
        @(posedge clk); #1;
        push(0, 0); push(2, 0);
        start   = 1'b1;
        tt_in   = 16'hAA25;
        m_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            wait_valid();
            m_ready = 1'b1;
            @(posedge clk); #1;
            m_ready = 1'b0;
        end
        wait_valid();
        check("emit_hold_index5", {28'd0, m_index}, 32'd5);
        check("emit_index5_not_last", {31'd0, m_last}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_valid", {31'd0, m_valid}, 32'd0);
        check("async_rst_last", {31'd0, m_last}, 32'd0);
        check("async_rst_index", {28'd0, m_index}, 32'd0);
        check("async_rst_count", {27'd0, count}, 32'd0);
        check("async_rst_done", {31'd0, done}, 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        exp_q.delete();
        push(2, 1);
        run(16'h0004, 1'b0, 1'b0, 1'b0, lf, ld);
        check("post_rst_first_latency", lf, 32'd4);
        check("post_rst_count", {27'd0, count}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/minterm_extractor.md
MINTERM_EXTRACTOR -- requirements
Module: minterm_extractor

Interface
REQ-001 Parameter: N_VARS, default 4, number of Boolean input variables; truth-table width is 2**N_VARS.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: start  input  1  request to capture tt_in and begin extraction; honoured only in IDLE.
REQ-005 Port: tt_in  input  2**N_VARS  truth table; bit k is f at input index k.
REQ-006 Port: busy  output  1  high in every state except IDLE.
REQ-007 Port: m_valid  output  1  minterm index available.
REQ-008 Port: m_ready  input  1  consumer accepts index.
REQ-009 Port: m_index  output  N_VARS  current minterm index.
REQ-010 Port: m_last  output  1  qualifies m_valid; no further set bit above m_index.
REQ-011 Port: done  output  1  one-cycle pulse at end of extraction.
REQ-012 Port: count  output  N_VARS+1  number of indices emitted in the last run.

Function
REQ-013 FSM states SHALL be IDLE, SCAN, EMIT, DONE.
REQ-014 IDLE: start=1 SHALL capture tt_in, clear count, set scan index to 0, enter SCAN next cycle.
REQ-015 start while busy SHALL be ignored; captured table SHALL not change mid-run.
REQ-016 SCAN at index i: captured bit i set -> EMIT next cycle with m_valid=1, m_index=i; bit clear and i<max -> i+1; bit clear and i=max -> DONE.
REQ-017 Each clear table bit SHALL cost exactly one SCAN cycle; start-to-first-m_valid latency = 2 + (index of lowest set bit) cycles.
REQ-018 EMIT: m_valid, m_index, m_last SHALL hold stable until m_valid&m_ready; no combinational path m_ready->m_valid.
REQ-019 On transfer: count increments; i=max -> DONE, else i+1 and SCAN; m_valid drops the following cycle.
REQ-020 m_last SHALL equal 1 iff no captured bit above m_index is set.
REQ-021 All-zero table: no m_valid, DONE after 2**N_VARS SCAN cycles, count=0.
REQ-022 All-ones table: 2**N_VARS transfers; count=2**N_VARS without overflow.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE; count held until next accepted start.
REQ-024 Indices SHALL be emitted strictly ascending, each set bit exactly once.

Reset
REQ-025 rst_n low SHALL, asynchronously and at any state including mid-EMIT, force IDLE, busy=0, m_valid=0, m_last=0, done=0, m_index=0, count=0, captured table=0.
REQ-026 First start SHALL be honoured on the first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro MINTERM_EXTRACTOR_MAXTERM_EN defined: extra input port sel_max (1 bit, sampled with start); sel_max=1 SHALL extract clear bits (maxterms) by inverting the captured table; m_last/count apply to the inverted table.
REQ-028 Macro undefined: sel_max port absent; minterms only.

Structure
REQ-029 Shared package minterm_pkg SHALL hold N_VARS default, table-width constant, and the FSM state enum.
REQ-030 One sub-module, minterm_any_above, SHALL compute the OR of captured bits above a given index for m_last.

Verification
REQ-031 tt_in=16'hAA25, m_ready=1 -> indices 0,2,5,9,11,13,15; m_last only on 15; count=7; one done pulse.
REQ-032 tt_in=16'h0000 -> no m_valid; done 17 cycles after start; count=0.
REQ-033 tt_in=16'hFFFF, m_ready toggling 1/0 -> indices 0..15 in order, m_index stable while stalled, count=16.
REQ-034 start with tt_in=16'h8000, second start with 16'h0001 while busy -> single index 15, second start ignored.
REQ-035 rst_n low while EMIT holds index 5 of 16'hAA25 -> all outputs zero immediately; fresh start with 16'h0004 yields index 2, count=1.
REQ-036 With MINTERM_EXTRACTOR_MAXTERM_EN, sel_max=1, tt_in=16'hAA25 -> indices 1,3,4,6,7,8,10,12,14; count=9.
